// File: rtl/axi_wr_slave.sv
// AXI3 write-channel slave: AW command FIFO, W beat consumer with FIXED/INCR/WRAP
// address generation, registered memory write port and B response with SLVERR reporting.
module axi_wr_slave #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int LEN_W    = 4,
    parameter int AW_DEPTH = 4
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [LEN_W-1:0]    awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     wid,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb
);

    localparam int PTR_W = $clog2(AW_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    cmd_t              fifo_mem [AW_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, push, pop, w_hs;
    cmd_t              head, cmd;
    state_t            state, state_next;
    logic [LEN_W-1:0]  beat;
    logic [ADDR_W-1:0] cur_addr, next_addr, bytes, span;
    logic              err, cmd_err, head_bad;

    function automatic logic check_cmd(cmd_t c);
        logic bad;
        bad = 1'b0;
        if (c.burst == 2'b11)
            bad = 1'b1;
        if ((32'd8 << c.size) > DATA_W)
            bad = 1'b1;
        if (c.burst == 2'b10) begin
            if (!(c.len == LEN_W'(1) || c.len == LEN_W'(3) || c.len == LEN_W'(7) || c.len == LEN_W'(15)))
                bad = 1'b1;
            if ((c.addr & ((ADDR_W'(1) << c.size) - ADDR_W'(1))) != '0)
                bad = 1'b1;
        end
        return bad;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // A pop in the same cycle never frees room for the push: full blocks outright.
    assign awready    = !fifo_full && !arst;
    assign push       = awvalid && awready;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign w_hs       = wvalid && wready;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_bad   = check_cmd(head);

    // NOTE: the FIFO storage carries no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge aclk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {awid, awaddr, awlen, awsize, awburst};
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bid        = '0;
        bresp      = 2'b00;
        case (state)
            IDLE: if (!fifo_empty) state_next = DATA;
            DATA: begin
                wready = 1'b1;
                if (w_hs && beat == cmd.len)
                    state_next = RESP;
            end
            RESP: begin
                bvalid = 1'b1;
                bid    = cmd.id;
                bresp  = err ? 2'b10 : 2'b00;
                if (bready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Span is a power of two only for legal WRAP lengths; illegal ones never write.
    assign bytes = ADDR_W'(1) << cmd.size;
    assign span  = (ADDR_W'(cmd.len) + ADDR_W'(1)) << cmd.size;

    always_comb begin
        next_addr = cur_addr;
        case (cmd.burst)
            2'b01:   next_addr = (cur_addr & ~(bytes - ADDR_W'(1))) + bytes;
            2'b10:   next_addr = (cur_addr & ~(span - ADDR_W'(1))) |
                                 ((cur_addr + bytes) & (span - ADDR_W'(1)));
            default: next_addr = cur_addr;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cmd       <= '0;
            beat      <= '0;
            cur_addr  <= '0;
            err       <= 1'b0;
            cmd_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            if (pop) begin
                cmd      <= head;
                beat     <= '0;
                cur_addr <= head.addr;
                cmd_err  <= head_bad;
                err      <= head_bad;
            end
            if (w_hs) begin
                beat     <= beat + LEN_W'(1);
                cur_addr <= next_addr;
                // A bad command suppresses the whole burst; a wrong WID only drops its own beat.
                if (!cmd_err && wid == cmd.id) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= cur_addr;
                    mem_wdata <= wdata;
                    mem_wstrb <= wstrb;
                end
                if (wid != cmd.id || wlast != (beat == cmd.len))
                    err <= 1'b1;
            end
            if (bvalid && bready)
                err <= 1'b0;
        end
    end

endmodule
